// File: rtl/vote_tally_seg.sv
// vote_tally_seg: serial vote tally; start/comps in, busy/done/count/majority/tie/segs out
module vote_tally_seg #(
  parameter int N_VOTERS = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  localparam int CW = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] comps,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       count,
  output logic                majority,
  output logic                tie,
  output logic [6:0]          segs
);
  typedef enum logic {IDLE, COUNT} state_e;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [CW:0] NV = (CW+1)'(N_VOTERS);
  localparam logic [6:0] BLANK = {7{SEG_ACTIVE_LOW}};
  state_e state_q, state_d;
  logic [N_VOTERS-1:0] snap_q, snap_d;
  logic [CW-1:0] acc_q, acc_d, idx_q, idx_d, count_q, count_d, sum;
  logic done_q, done_d, maj_q, maj_d, tie_q, tie_d, last;
  logic [6:0] segs_q, segs_d;
  always_comb begin
    sum = acc_q + CW'(snap_q[0]);
    last = (state_q == COUNT) && (idx_q == CW'(N_VOTERS - 1));
    state_d = state_q;
    snap_d = snap_q;
    acc_d = acc_q;
    idx_d = idx_q;
    count_d = count_q;
    maj_d = maj_q;
    tie_d = tie_q;
    segs_d = segs_q;
    done_d = last;
    if (state_q == IDLE && start) begin
      state_d = COUNT;
      snap_d = comps;
      acc_d = '0;
      idx_d = '0;
    end else if (state_q == COUNT) begin
      snap_d = snap_q >> 1;
      acc_d = sum;
      idx_d = idx_q + CW'(1);
      if (last) begin
        state_d = IDLE;
        count_d = sum;
        maj_d = {sum, 1'b0} > NV;
        tie_d = {sum, 1'b0} == NV;
        segs_d = SEG_LUT[4'(sum)] ^ BLANK;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      count_q <= '0;
      maj_q <= 1'b0;
      tie_q <= 1'b0;
      segs_q <= BLANK;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      count_q <= count_d;
      maj_q <= maj_d;
      tie_q <= tie_d;
      segs_q <= segs_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == COUNT;
  assign done = done_q;
  assign count = count_q;
  assign majority = maj_q;
  assign tie = tie_q;
  assign segs = segs_q;
endmodule
